image_cell_engine: RTL and testbench
====================================

IMAGE_CELL_ENGINE -- requirements
Module: image_cell_engine

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning pixel matrix dimension (N x N pixels per cell).
REQ-002 The block SHALL have parameter CHAN_W, default 8, meaning bits per colour channel.
REQ-003 The block SHALL have parameter CHANNELS, default 3, meaning channels per pixel; channel CHANNELS-1 is most significant (red for 24-bit RGB).
REQ-004 The block SHALL have parameter LANES, default 4, meaning pixels processed per clock; N*N SHALL be a multiple of LANES, else elaboration fails.
REQ-005 Derived: PIX_W = CHAN_W*CHANNELS; CELL_W = N*N*PIX_W; BEATS = N*N/LANES.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 in_valid  in  1  operand set offered.
REQ-009 in_ready  out  1  engine can accept an operand set.
REQ-010 opcode  in  3  operation, sampled on accept.
REQ-011 cell_a  in  CELL_W  operand A; pixel (i,j) at bits [(i*N+j)*PIX_W +: PIX_W]; channel c at [c*CHAN_W +: CHAN_W] within pixel.
REQ-012 cell_b  in  CELL_W  operand B, same packing.
REQ-013 out_valid  out  1  result available.
REQ-014 out_ready  in  1  consumer accepts result.
REQ-015 result  out  CELL_W  result cell, same packing.
REQ-016 sat  out  1  at least one channel saturated during the operation.
REQ-017 err  out  1  opcode was illegal.

Function
REQ-018 Opcodes: 0 ADD, 1 SUB, 2 AVG, 3 MAX, 4 MIN, 5..7 illegal; all per channel, unsigned.
REQ-019 ADD SHALL compute a+b clamped to 2^CHAN_W-1; clamp sets sat.
REQ-020 SUB SHALL compute a-b clamped to 0; clamp sets sat.
REQ-021 AVG SHALL compute (a+b)>>1 using a CHAN_W+1-bit sum, truncating; never sets sat.
REQ-022 MAX/MIN SHALL select the larger/smaller channel value; never set sat.
REQ-023 Illegal opcode SHALL produce an all-zero result, err=1, sat=0, same latency as legal ops.
REQ-024 FSM states IDLE, BUSY, DONE; IDLE->BUSY on in_valid&in_ready; BUSY->DONE after BEATS beats; DONE->IDLE on out_valid&out_ready.
REQ-025 in_ready SHALL be 1 only in IDLE; on accept, opcode, cell_a, cell_b SHALL be registered internally and later input changes SHALL not affect the operation.
REQ-026 In BUSY, a beat counter 0..BEATS-1 SHALL select pixels k*LANES..k*LANES+LANES-1 on beat k and write their results; counter wraps to 0 on entering DONE.
REQ-027 out_valid SHALL rise exactly BEATS cycles after the accepting edge (default 4) and be 1 only in DONE.
REQ-028 result, sat, err SHALL be stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-029 sat SHALL clear on each accept and accumulate (OR) over all beats.
REQ-030 in_valid during BUSY/DONE SHALL be ignored (no accept, no state change).
REQ-031 Back-to-back: DONE->IDLE handshake and next accept SHALL occur on consecutive edges (one IDLE cycle minimum).

Reset
REQ-032 reset=1 SHALL asynchronously force IDLE, beat counter 0, in_ready=1, out_valid=0, result=0, sat=0, err=0.
REQ-033 reset asserted in BUSY or DONE SHALL abort the operation with no result delivered; first accept after release behaves as from power-up.

Verification
REQ-034 ADD, A all 24'h000000, B all 24'h00FF00 -> after 4 cycles every pixel 24'h00FF00, sat=0, err=0.
REQ-035 ADD, A=B all 24'hFF0000 -> every pixel 24'hFF0000, sat=1; SUB A=24'h000000, B=24'hFFFFFF -> 24'h000000, sat=1.
REQ-036 AVG, A all 24'hFFFFFF, B all 24'h000000 -> every pixel 24'h7F7F7F, sat=0; MAX/MIN of 24'h12AB34 and 24'h34AB12 -> 24'h34AB34 / 24'h12AB12.
REQ-037 out_ready held 0 for 5 cycles after out_valid -> result/sat/err constant, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-038 opcode 3'b111 -> result 0, err=1, out_valid after 4 cycles; reset pulsed during beat 2 of an ADD -> out_valid never rises, outputs 0, in_ready=1 immediately.
REQ-039 Parameter sweep N=2/LANES=1 (BEATS=4) and N=4/LANES=16 (BEATS=1) -> REQ-034 values with latency BEATS.

Source files
------------

// File: rtl/image_cell_engine.sv
// Per-channel pixel arithmetic engine: accepts two N x N pixel cells and an opcode, then
// processes LANES pixels per clock over BEATS cycles before presenting the result cell.
module image_cell_engine #(
  parameter int unsigned N        = 4,
  parameter int unsigned CHAN_W   = 8,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned LANES    = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [2:0]                         opcode,
  input  logic [N*N*CHAN_W*CHANNELS-1:0]     cell_a,
  input  logic [N*N*CHAN_W*CHANNELS-1:0]     cell_b,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [N*N*CHAN_W*CHANNELS-1:0]     result,
  output logic                               sat,
  output logic                               err
);

  localparam int unsigned PIX_W  = CHAN_W * CHANNELS;
  localparam int unsigned CELL_W = N * N * PIX_W;
  localparam int unsigned BEATS  = (N * N) / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAvg = 3'd2;
  localparam logic [2:0] OpMax = 3'd3;
  localparam logic [2:0] OpMin = 3'd4;

  if ((N * N) % LANES != 0) begin : g_bad_lanes
    $error("image_cell_engine: N*N must be a multiple of LANES");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [2:0]          op_q, op_d;
  logic [CELL_W-1:0]   a_q, a_d;
  logic [CELL_W-1:0]   b_q, b_d;
  logic [CELL_W-1:0]   res_q, res_d;
  logic                sat_q, sat_d;
  logic                err_q, err_d;

  logic [CHAN_W-1:0]   ch_a, ch_b, ch_r;
  logic [CHAN_W:0]     ch_sum;
  logic                ch_sat;
  int unsigned         pix_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      beat_q  <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    sat_d     = sat_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    ch_a      = '0;
    ch_b      = '0;
    ch_r      = '0;
    ch_sum    = '0;
    ch_sat    = 1'b0;
    pix_idx   = 0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = StBusy;
          beat_d  = '0;
          op_d    = opcode;
          a_d     = cell_a;
          b_d     = cell_b;
          sat_d   = 1'b0;
          err_d   = (opcode > OpMin);
        end
      end

      StBusy: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          pix_idx = 32'(beat_q) * LANES + l;
          for (int unsigned c = 0; c < CHANNELS; c++) begin
            ch_a   = a_q[pix_idx*PIX_W + c*CHAN_W +: CHAN_W];
            ch_b   = b_q[pix_idx*PIX_W + c*CHAN_W +: CHAN_W];
            ch_sum = {1'b0, ch_a} + {1'b0, ch_b};
            ch_sat = 1'b0;
            case (op_q)
              OpAdd: begin
                ch_sat = ch_sum[CHAN_W];
                ch_r   = ch_sat ? '1 : ch_sum[CHAN_W-1:0];
              end
              OpSub: begin
                ch_sat = (ch_a < ch_b);
                ch_r   = ch_sat ? '0 : ch_a - ch_b;
              end
              OpAvg:   ch_r = ch_sum[CHAN_W:1];
              OpMax:   ch_r = (ch_a > ch_b) ? ch_a : ch_b;
              OpMin:   ch_r = (ch_a < ch_b) ? ch_a : ch_b;
              default: ch_r = '0;
            endcase
            res_d[pix_idx*PIX_W + c*CHAN_W +: CHAN_W] = ch_r;
            sat_d = sat_d | ch_sat;
          end
        end
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          beat_d  = '0;
          state_d = StDone;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end

      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign result = res_q;
  assign sat    = sat_q;
  assign err    = err_q;

endmodule

// File: tb/tb_image_cell_engine.sv
// Directed self-checking bench for image_cell_engine: default build plus two parameter variants.
module tb_image_cell_engine;

  localparam int unsigned CW  = 384;  // N=4, 24-bit pixels
  localparam int unsigned CW2 = 96;   // N=2, 24-bit pixels

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    opcode = '0;
  logic [CW-1:0] cell_a = '0;
  logic [CW-1:0] cell_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] result;
  logic          sat;
  logic          err;

  logic           v2 = 1'b0, v3 = 1'b0;
  logic           ir2, ir3, ov2, ov3, sat2, sat3, err2, err3;
  logic [CW2-1:0] a2 = '0, b2 = '0, res2;
  logic [CW-1:0]  a3 = '0, b3 = '0, res3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  image_cell_engine dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .cell_a(cell_a), .cell_b(cell_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .sat(sat), .err(err)
  );

  image_cell_engine #(.N(2), .LANES(1)) dut_n2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_ready(ir2), .opcode(3'd0),
    .cell_a(a2), .cell_b(b2), .out_valid(ov2), .out_ready(1'b0),
    .result(res2), .sat(sat2), .err(err2)
  );

  image_cell_engine #(.N(4), .LANES(16)) dut_l16 (
    .clk(clk), .reset(reset), .in_valid(v3), .in_ready(ir3), .opcode(3'd0),
    .cell_a(a3), .cell_b(b3), .out_valid(ov3), .out_ready(1'b0),
    .result(res3), .sat(sat3), .err(err3)
  );

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Offers one operation, scrambles the inputs after accept, and measures latency to out_valid.
  task automatic run_op(input logic [2:0] op, input logic [23:0] pa, input logic [23:0] pb,
                        output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = op;
    cell_a   = {16{pa}};
    cell_b   = {16{pb}};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    opcode   = op + 3'd1;
    cell_a   = {16{24'h5A5A5A}};
    cell_b   = {16{24'hA5C3E1}};
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat = c;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat, lat2, lat3, seen;

    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, '0);
    check("rst_sat_err", {sat, err}, 2'b00);
    @(negedge clk);
    reset = 1'b0;

    run_op(3'd0, 24'h000000, 24'h00FF00, lat);
    check("add_lat", lat, 4);
    check("add_result", result, {16{24'h00FF00}});
    check("add_sat_err", {sat, err}, 2'b00);
    release_out();
    check("add_idle_ready", in_ready, 1'b1);
    check("add_idle_valid", out_valid, 1'b0);

    run_op(3'd0, 24'hFF0000, 24'hFF0000, lat);
    check("addsat_result", result, {16{24'hFF0000}});
    check("addsat_sat", sat, 1'b1);
    release_out();

    run_op(3'd1, 24'h000000, 24'hFFFFFF, lat);
    check("sub_result", result, {16{24'h000000}});
    check("sub_sat", sat, 1'b1);
    release_out();

    run_op(3'd2, 24'hFFFFFF, 24'h000000, lat);
    check("avg_result", result, {16{24'h7F7F7F}});
    check("avg_sat", sat, 1'b0);
    release_out();

    run_op(3'd4, 24'h12AB34, 24'h34AB12, lat);
    check("min_result", result, {16{24'h12AB12}});
    release_out();

    run_op(3'd3, 24'h12AB34, 24'h34AB12, lat);
    check("max_result", result, {16{24'h34AB34}});
    // Stall the consumer while poking in_valid; nothing may move.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      cell_a   = {16{24'h010203}};
      @(posedge clk);
      #1;
      check("hold_result", result, {16{24'h34AB34}});
      check("hold_flags", {out_valid, in_ready, sat, err}, 4'b1000);
    end
    release_out();
    check("hold_release", {in_ready, out_valid}, 2'b10);

    run_op(3'd7, 24'h123456, 24'h654321, lat);
    check("ill_lat", lat, 4);
    check("ill_result", result, '0);
    check("ill_flags", {sat, err}, 2'b01);
    release_out();

    // Abort an ADD during its third beat.
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = 3'd0;
    cell_a   = {16{24'h101010}};
    cell_b   = {16{24'h202020}};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("abort_ready", in_ready, 1'b1);
    check("abort_valid", out_valid, 1'b0);
    check("abort_result", result, '0);
    check("abort_flags", {sat, err}, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort_no_valid", seen, 0);

    run_op(3'd0, 24'h000000, 24'h00FF00, lat);
    check("post_rst_lat", lat, 4);
    check("post_rst_result", result, {16{24'h00FF00}});
    release_out();

    @(negedge clk);
    v2 = 1'b1;
    v3 = 1'b1;
    b2 = {4{24'h00FF00}};
    b3 = {16{24'h00FF00}};
    @(posedge clk);
    #1;
    v2 = 1'b0;
    v3 = 1'b0;
    lat2 = 0;
    lat3 = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (ov2 && lat2 == 0) lat2 = c;
      if (ov3 && lat3 == 0) lat3 = c;
    end
    check("n2_lat", lat2, 4);
    check("n2_result", res2, {4{24'h00FF00}});
    check("n2_flags", {sat2, err2}, 2'b00);
    check("l16_lat", lat3, 1);
    check("l16_result", res3, {16{24'h00FF00}});
    check("l16_flags", {sat3, err3}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
